// File: rtl/alu_sys_pkg.sv
// Shared types and constants for the ALU result output path.
// Imported by the serializer and its result FIFO.
package alu_sys_pkg;

   localparam int BYTE_W = 8;
   localparam int DEF_RES_WIDTH = 16;

   typedef enum logic {
      IDLE = 1'b0,
      SEND = 1'b1
   } state_e;

endpackage

// File: rtl/result_fifo.sv
// Single-clock result FIFO with wrap-around pointers and a separate count.
// A push into a full FIFO is taken only when a pop happens in the same cycle.
module result_fifo
   import alu_sys_pkg::*;
#(
   parameter int WIDTH = DEF_RES_WIDTH,
   parameter int DEPTH = 4
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         push,
   input  logic [WIDTH-1:0]             wdata,
   input  logic                         pop,
   output logic [WIDTH-1:0]             rdata,
   output logic                         full,
   output logic                         empty,
   output logic [$clog2(DEPTH+1)-1:0]   count
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = $clog2(DEPTH+1);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic             do_push;
   logic             do_pop;

   assign full  = (count_q == CNT_W'(DEPTH));
   assign empty = (count_q == '0);
   assign count = count_q;
   assign rdata = mem_q[rd_ptr_q];

   assign do_pop  = pop & ~empty;
   assign do_push = push & (~full | do_pop);

   always_comb begin
      wr_ptr_d = wr_ptr_q + PTR_W'(do_push);
      rd_ptr_d = rd_ptr_q + PTR_W'(do_pop);
      count_d  = count_q;
      if (do_push & ~do_pop) begin
         count_d = count_q + 1'b1;
      end else if (do_pop & ~do_push) begin
         count_d = count_q - 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // Storage needs no reset: the count gates every read.
   always_ff @(posedge clk) begin
      if (do_push) begin
         mem_q[wr_ptr_q] <= wdata;
      end
   end

endmodule

// File: rtl/alu_result_serializer.sv
// Buffers ALU results and sends each one LSB-first as bytes over valid/ready.
// Results arriving while the buffer is full are dropped and flagged.
module alu_result_serializer
   import alu_sys_pkg::*;
#(
   parameter int RES_WIDTH = DEF_RES_WIDTH,
   parameter int DEPTH     = 4
) (
   input  logic                         i_Ref_clk,
   input  logic                         i_rst,
   input  logic [RES_WIDTH-1:0]         i_alu_out,
   input  logic                         i_Vid_ALU,
   output logic [BYTE_W-1:0]            o_tx_data,
   output logic                         o_tx_valid,
   input  logic                         i_tx_ready,
   output logic [$clog2(DEPTH+1)-1:0]   o_level,
   output logic                         o_busy,
   output logic                         o_overflow,
   input  logic                         i_ovf_clr
);

   localparam int NBYTES = RES_WIDTH / BYTE_W;
   localparam int IDX_W  = (NBYTES > 1) ? $clog2(NBYTES) : 1;

   logic [RES_WIDTH-1:0] head;
   logic                 full;
   logic                 empty;
   logic                 push;
   logic                 pop;
   logic                 xfer;
   logic                 last;

   state_e               state_q, state_d;
   logic [RES_WIDTH-1:0] shift_q, shift_d;
   logic [IDX_W-1:0]     idx_q, idx_d;
   logic                 valid_q, valid_d;
   logic                 ovf_q, ovf_d;

   result_fifo #(
      .WIDTH (RES_WIDTH),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk   (i_Ref_clk),
      .rst   (i_rst),
      .push  (push),
      .wdata (i_alu_out),
      .pop   (pop),
      .rdata (head),
      .full  (full),
      .empty (empty),
      .count (o_level)
   );

   assign xfer = valid_q & i_tx_ready;
   assign last = (idx_q == IDX_W'(NBYTES-1));
   assign push = i_Vid_ALU & (~full | pop);

   always_comb begin
      state_d = state_q;
      shift_d = shift_q;
      idx_d   = idx_q;
      valid_d = valid_q;
      pop     = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (!empty) begin
               pop     = 1'b1;
               shift_d = head;
               idx_d   = '0;
               valid_d = 1'b1;
               state_d = SEND;
            end
         end
         SEND: begin
            if (xfer) begin
               if (!last) begin
                  shift_d = shift_q >> BYTE_W;
                  idx_d   = idx_q + 1'b1;
               end else if (!empty) begin
                  pop     = 1'b1;
                  shift_d = head;
                  idx_d   = '0;
               end else begin
                  valid_d = 1'b0;
                  state_d = IDLE;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // A drop in the same cycle as a clear leaves the flag set.
   assign ovf_d = (i_Vid_ALU & ~push) | (ovf_q & ~i_ovf_clr);

   always_ff @(posedge i_Ref_clk) begin
      if (i_rst) begin
         state_q <= IDLE;
         shift_q <= '0;
         idx_q   <= '0;
         valid_q <= 1'b0;
         ovf_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         shift_q <= shift_d;
         idx_q   <= idx_d;
         valid_q <= valid_d;
         ovf_q   <= ovf_d;
      end
   end

   assign o_tx_data  = shift_q[BYTE_W-1:0];
   assign o_tx_valid = valid_q;
   assign o_overflow = ovf_q;
   assign o_busy     = (state_q != IDLE) | ~empty;

endmodule

// File: tb/tb_alu_result_serializer.sv
// Directed and random checks of the ALU result byte serializer.
// Expected bytes come from a queue filled as results are accepted.
module tb_alu_result_serializer;

   localparam int RW     = 16;
   localparam int DEPTH  = 4;
   localparam int NBYTES = RW / 8;

   logic          clk = 1'b0;
   logic          i_rst;
   logic [RW-1:0] i_alu_out;
   logic          i_Vid_ALU;
   logic [7:0]    o_tx_data;
   logic          o_tx_valid;
   logic          i_tx_ready;
   logic [2:0]    o_level;
   logic          o_busy;
   logic          o_overflow;
   logic          i_ovf_clr;

   int            ncmp = 0;
   int            nerr = 0;
   logic [7:0]    exp_q[$];
   int            pushed = 0;
   int            bytes_rx = 0;
   logic          hold_pend = 1'b0;
   logic [7:0]    hold_data = 8'h00;

   alu_result_serializer #(
      .RES_WIDTH (RW),
      .DEPTH     (DEPTH)
   ) dut (
      .i_Ref_clk  (clk),
      .i_rst      (i_rst),
      .i_alu_out  (i_alu_out),
      .i_Vid_ALU  (i_Vid_ALU),
      .o_tx_data  (o_tx_data),
      .o_tx_valid (o_tx_valid),
      .i_tx_ready (i_tx_ready),
      .o_level    (o_level),
      .o_busy     (o_busy),
      .o_overflow (o_overflow),
      .i_ovf_clr  (i_ovf_clr)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs,
                        input logic [31:0] exp);
      ncmp++;
      assert (obs === exp) else begin
         nerr++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // One clock: score any transfer seen before the edge, then advance.
   task automatic tick(input logic vid, input logic [RW-1:0] w,
                       input logic rdy, input logic acc, input logic clr);
      i_Vid_ALU  = vid;
      i_alu_out  = w;
      i_tx_ready = rdy;
      i_ovf_clr  = clr;
      #1;
      if (hold_pend) begin
         check("hold_valid", o_tx_valid, 1);
         check("hold_data", o_tx_data, hold_data);
      end
      if (o_tx_valid && rdy && !i_rst) begin
         check("byte_expected", exp_q.size() != 0, 1);
         if (exp_q.size() != 0) check("byte", o_tx_data, exp_q.pop_front());
         bytes_rx++;
      end
      hold_pend = o_tx_valid && !rdy && !i_rst;
      hold_data = o_tx_data;
      if (vid && acc && !i_rst) begin
         for (int b = 0; b < NBYTES; b++) exp_q.push_back(8'((w >> (8*b)) & 'hFF));
         pushed++;
      end
      @(posedge clk);
      #1;
      i_Vid_ALU = 1'b0;
      i_ovf_clr = 1'b0;
   endtask

   task automatic drain(output int n);
      n = 0;
      while (exp_q.size() != 0 && n < 200) begin
         tick(1'b0, '0, 1'b1, 1'b0, 1'b0);
         n++;
      end
      check("drain_empty", exp_q.size(), 0);
   endtask

   initial begin
      int n;
      int bad;
      logic [RW-1:0] w;
      logic vid, rdy;
      i_rst = 1'b1; i_alu_out = '0; i_Vid_ALU = 1'b0;
      i_tx_ready = 1'b0; i_ovf_clr = 1'b0;
      tick(0, '0, 0, 0, 0);
      tick(0, '0, 0, 0, 0);
      check("rst_valid", o_tx_valid, 0);
      check("rst_data", o_tx_data, 0);
      check("rst_level", o_level, 0);
      check("rst_busy", o_busy, 0);
      check("rst_ovf", o_overflow, 0);
      i_rst = 1'b0;
      tick(0, '0, 1, 0, 0);

      // Single result, latency and busy
      tick(1, 16'hA55A, 1, 1, 0);
      check("lat_valid_k", o_tx_valid, 0);
      check("lat_level_k", o_level, 1);
      tick(0, '0, 1, 0, 0);
      check("lat_valid_k1", o_tx_valid, 1);
      check("lat_lsb", o_tx_data, 8'h5A);
      tick(0, '0, 1, 0, 0);
      check("lat_msb", o_tx_data, 8'hA5);
      tick(0, '0, 1, 0, 0);
      check("single_done_valid", o_tx_valid, 0);
      check("single_done_busy", o_busy, 0);

      // Burst of four, no gaps
      tick(1, 16'h0001, 1, 1, 0);
      tick(1, 16'h0203, 1, 1, 0);
      tick(1, 16'h0405, 1, 1, 0);
      tick(1, 16'h0607, 1, 1, 0);
      drain(n);
      check("burst_cycles", n, 6);

      // Long back-pressure
      tick(1, 16'hA55A, 0, 1, 0);
      bad = 0;
      for (int i = 0; i < 20; i++) begin
         tick(0, '0, 0, 0, 0);
         if (!(o_tx_valid === 1'b1 && o_tx_data === 8'h5A)) bad++;
      end
      check("stall_stable", bad, 0);
      drain(n);
      check("stall_cycles", n, 2);

      // Overflow: one word held in the output stage, four queued, two dropped
      tick(1, 16'h1111, 0, 1, 0);
      tick(0, '0, 0, 0, 0);
      tick(1, 16'h2101, 0, 1, 0);
      tick(1, 16'h2202, 0, 1, 0);
      tick(1, 16'h2303, 0, 1, 0);
      tick(1, 16'h2404, 0, 1, 0);
      check("ovf_level_full", o_level, 4);
      check("ovf_not_yet", o_overflow, 0);
      tick(1, 16'h2505, 0, 0, 0);
      check("ovf_set", o_overflow, 1);
      tick(1, 16'h2606, 0, 0, 0);
      check("ovf_level_held", o_level, 4);
      tick(0, '0, 0, 0, 1);
      check("ovf_cleared", o_overflow, 0);
      drain(n);
      check("ovf_drain_cycles", n, 10);

      // Full FIFO, final byte accepted alongside a new result
      tick(1, 16'h3030, 0, 1, 0);
      tick(1, 16'h3101, 0, 1, 0);
      tick(1, 16'h3202, 0, 1, 0);
      tick(1, 16'h3303, 0, 1, 0);
      tick(1, 16'h3404, 0, 1, 0);
      check("pp_level_pre", o_level, 4);
      tick(0, '0, 1, 0, 0);
      tick(1, 16'h3C3C, 1, 1, 0);
      check("pp_level", o_level, 4);
      check("pp_no_ovf", o_overflow, 0);
      drain(n);
      check("pp_drain_cycles", n, 10);

      // Reset in the middle of a frame
      tick(1, 16'h1234, 1, 1, 0);
      tick(0, '0, 1, 0, 0);
      tick(0, '0, 1, 0, 0);
      i_rst = 1'b1;
      tick(0, '0, 0, 0, 0);
      exp_q.delete();
      pushed = 0;
      bytes_rx = 0;
      check("mid_rst_valid", o_tx_valid, 0);
      check("mid_rst_level", o_level, 0);
      check("mid_rst_busy", o_busy, 0);
      i_rst = 1'b0;
      tick(1, 16'hBEEF, 1, 1, 0);
      drain(n);
      check("post_rst_cycles", n, 3);

      // Random traffic kept within capacity
      for (int i = 0; i < 400; i++) begin
         rdy = ($urandom_range(0, 3) != 0);
         vid = ((pushed - bytes_rx / NBYTES) < DEPTH) && ($urandom_range(0, 1) == 1);
         w   = RW'($urandom);
         tick(vid, w, rdy, 1, 0);
      end
      drain(n);
      tick(0, '0, 1, 0, 0);
      check("rand_ovf", o_overflow, 0);
      check("rand_level", o_level, 0);
      check("rand_busy", o_busy, 0);
      check("rand_words", bytes_rx, pushed * NBYTES);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
      $finish;
   end

endmodule
